// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe completion TLP constants, attribute record, FSM state type and
// byte-enable helpers used by the PIO completion path (no logic, no latency).
package pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_ND    = 2'b00;
    localparam logic [1:0] FMT_3DW_D     = 2'b10;
    localparam logic [4:0] TYPE_CPL      = 5'b01010;
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_BEAT0,
        ST_BEAT1
    } cpl_state_e;

    // addr holds the DW address req_addr[12:2]; the low two bits are implied by be.
    typedef struct packed {
        logic        wd;
        logic        ur;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [10:0] addr;
        logic [3:0]  be;
    } cpl_attr_t;

    function automatic logic is_cpld(input cpl_attr_t a);
        return a.wd && !a.ur;
    endfunction

    function automatic logic [11:0] be_to_byte_count(input logic [3:0] be);
        logic [11:0] bc;
        casez (be)
            4'b1??1:                   bc = 12'd4;
            4'b01?1, 4'b1?10:          bc = 12'd3;
            4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
            default:                   bc = 12'd1;
        endcase
        return bc;
    endfunction

    function automatic logic [1:0] be_to_lower_addr_off(input logic [3:0] be);
        logic [1:0] off;
        casez (be)
            4'b???1: off = 2'b00;
            4'b??10: off = 2'b01;
            4'b?100: off = 2'b10;
            4'b1000: off = 2'b11;
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/pio_tx_compl_engine_if.sv
// 64-bit AXI4-Stream TX channel carrying completion TLPs.
// Pure wiring: no latency; the slave throttles the master with tready.
interface pio_tx_compl_engine_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/pio_cpl_hdr_build.sv
// Formats completion header DW0..DW2 from a captured request attribute record.
// Purely combinational, zero latency; no flow control of its own.
module pio_cpl_hdr_build
    import pcie_tlp_pkg::*;
(
    input  logic [15:0] completer_id,
    input  cpl_attr_t   attr,
    output logic [31:0] dw0,
    output logic [31:0] dw1,
    output logic [31:0] dw2
);

    logic cpld;
    logic unused_addr_hi;

    assign unused_addr_hi = ^attr.addr[10:5];

    always_comb begin
        cpld = is_cpld(attr);
        dw0  = {1'b0, (cpld ? FMT_3DW_D : FMT_3DW_ND), TYPE_CPL, 1'b0, attr.tc, 4'b0000,
                1'b0, 1'b0, attr.attr, 2'b00, (cpld ? 10'd1 : 10'd0)};
        dw1  = {completer_id, (attr.ur ? CPL_STATUS_UR : CPL_STATUS_SC), 1'b0,
                be_to_byte_count(attr.be)};
        dw2  = {attr.rid, attr.tag, 1'b0, attr.addr[4:0], be_to_lower_addr_off(attr.be)};
    end

endmodule

// File: rtl/pio_tx_compl_engine.sv
// PIO completion engine: one request -> optional 1-DW memory read -> 2-beat CplD/Cpl TLP.
// Latency: RD_LATENCY+2 cycles to first beat for CplD, 1 for Cpl; beats hold stable while tready is low.
module pio_tx_compl_engine
    import pcie_tlp_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           completer_id,
    input  logic                  req_compl,
    input  logic                  req_compl_wd,
    input  logic                  req_ur,
    input  logic [2:0]            req_tc,
    input  logic [1:0]            req_attr,
    input  logic [15:0]           req_rid,
    input  logic [7:0]            req_tag,
    input  logic [12:0]           req_addr,
    input  logic [3:0]            req_be,
    output logic                  rd_en,
    output logic [10:0]           rd_addr,
    input  logic [31:0]           rd_data,
    pio_tx_compl_engine_if.master m_axis,
    output logic                  compl_done,
    output logic                  req_drop
);

    if (C_DATA_WIDTH != 64) begin : g_bad_width
        $error("pio_tx_compl_engine supports only a 64-bit stream");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("pio_tx_compl_engine RD_LATENCY must be 1..7");
    end

    cpl_state_e  state_q, state_d;
    cpl_attr_t   attr_q, attr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        rd_en_q, rd_en_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic [63:0] tdata_q, tdata_d;
    logic        compl_done_q, compl_done_d;
    logic        req_drop_q, req_drop_d;
    logic        beat0_load;
    logic [31:0] hdr_dw0, hdr_dw1, hdr_dw2;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^req_addr[1:0];

    always_comb begin
        attr_d = attr_q;
        if (state_q == ST_IDLE && req_compl) begin
            attr_d.wd   = req_compl_wd;
            attr_d.ur   = req_ur;
            attr_d.tc   = req_tc;
            attr_d.attr = req_attr;
            attr_d.rid  = req_rid;
            attr_d.tag  = req_tag;
            attr_d.addr = req_addr[12:2];
            attr_d.be   = req_be;
        end
    end

    // Header is built from the next-cycle attributes so beat 0 can be registered
    // on the same edge that captures a no-data request.
    pio_cpl_hdr_build u_hdr (
        .completer_id (completer_id),
        .attr         (attr_d),
        .dw0          (hdr_dw0),
        .dw1          (hdr_dw1),
        .dw2          (hdr_dw2)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        rd_en_d      = 1'b0;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tkeep_d      = tkeep_q;
        tdata_d      = tdata_q;
        compl_done_d = 1'b0;
        req_drop_d   = req_drop_q | (req_compl && state_q != ST_IDLE);
        beat0_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_compl) begin
                    if (is_cpld(attr_d)) begin
                        rd_en_d = 1'b1;
                        cnt_d   = 3'(RD_LATENCY);
                        state_d = ST_RD_WAIT;
                    end else begin
                        beat0_load = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    data_d     = rd_data;
                    beat0_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_BEAT0: begin
                if (m_axis.tready) begin
                    state_d = ST_BEAT1;
                    tlast_d = 1'b1;
                    tkeep_d = is_cpld(attr_q) ? 8'hFF : 8'h0F;
                    tdata_d = {(is_cpld(attr_q) ? data_q : 32'h0), hdr_dw2};
                end
            end
            ST_BEAT1: begin
                if (m_axis.tready) begin
                    state_d      = ST_IDLE;
                    tvalid_d     = 1'b0;
                    tlast_d      = 1'b0;
                    tkeep_d      = 8'h00;
                    tdata_d      = 64'h0;
                    compl_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat0_load) begin
            state_d  = ST_BEAT0;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            tkeep_d  = 8'hFF;
            tdata_d  = {hdr_dw1, hdr_dw0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            attr_q       <= '0;
            cnt_q        <= 3'd0;
            data_q       <= 32'h0;
            rd_en_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tkeep_q      <= 8'h00;
            tdata_q      <= 64'h0;
            compl_done_q <= 1'b0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            attr_q       <= attr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            rd_en_q      <= rd_en_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tkeep_q      <= tkeep_d;
            tdata_q      <= tdata_d;
            compl_done_q <= compl_done_d;
            req_drop_q   <= req_drop_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = attr_q.addr;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tdata  = tdata_q;
    assign compl_done    = compl_done_q;
    assign req_drop      = req_drop_q;

endmodule

// File: tb/tb_pio_tx_compl_engine.sv
// Directed bench for pio_tx_compl_engine: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=3, each fed by a delay-line memory model; sel picks the active instance.
module tb_pio_tx_compl_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic [15:0] completer_id = 16'h0108;
    logic        req_compl = 1'b0, req_compl_wd = 1'b0, req_ur = 1'b0;
    logic [2:0]  req_tc = '0;
    logic [1:0]  req_attr = '0;
    logic [15:0] req_rid = '0;
    logic [7:0]  req_tag = '0;
    logic [12:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic        tready = 1'b0;
    int          sel = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        req_a, req_b;
    logic        rd_en_a, rd_en_b, done_a, done_b, drop_a, drop_b;
    logic [10:0] rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic [7:0]  pipe_a, pipe_b;
    logic [10:0] paddr_a [8];
    logic [10:0] paddr_b [8];

    pio_tx_compl_engine_if axis_a ();
    pio_tx_compl_engine_if axis_b ();
    assign axis_a.tready = tready;
    assign axis_b.tready = tready;
    assign req_a = req_compl && (sel == 0);
    assign req_b = req_compl && (sel == 1);

    pio_tx_compl_engine #(.RD_LATENCY(1), .C_DATA_WIDTH(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .completer_id(completer_id), .req_compl(req_a),
        .req_compl_wd(req_compl_wd), .req_ur(req_ur), .req_tc(req_tc), .req_attr(req_attr),
        .req_rid(req_rid), .req_tag(req_tag), .req_addr(req_addr), .req_be(req_be),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .m_axis(axis_a.master),
        .compl_done(done_a), .req_drop(drop_a));

    pio_tx_compl_engine #(.RD_LATENCY(3), .C_DATA_WIDTH(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .completer_id(completer_id), .req_compl(req_b),
        .req_compl_wd(req_compl_wd), .req_ur(req_ur), .req_tc(req_tc), .req_attr(req_attr),
        .req_rid(req_rid), .req_tag(req_tag), .req_addr(req_addr), .req_be(req_be),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .m_axis(axis_b.master),
        .compl_done(done_b), .req_drop(drop_b));

    function automatic logic [31:0] mem_val(input logic [10:0] a);
        if (a == 11'h004) return 32'hDEADBEEF;
        return {5'h15, a, 16'hC0DE};
    endfunction

    // Read data is only valid exactly RD_LATENCY cycles after rd_en; otherwise garbage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a     <= {pipe_a[6:0], rd_en_a};
            pipe_b     <= {pipe_b[6:0], rd_en_b};
            paddr_a[0] <= rd_addr_a;
            paddr_b[0] <= rd_addr_b;
            for (int i = 1; i < 8; i++) begin
                paddr_a[i] <= paddr_a[i-1];
                paddr_b[i] <= paddr_b[i-1];
            end
        end
    end
    assign rd_data_a = pipe_a[0] ? mem_val(paddr_a[0]) : 32'hBAD0BAD0;
    assign rd_data_b = pipe_b[2] ? mem_val(paddr_b[2]) : 32'hBAD0BAD0;

    logic        o_tvalid, o_tlast, o_rd_en, o_done, o_drop;
    logic [63:0] o_tdata;
    logic [7:0]  o_tkeep;
    logic [10:0] o_rd_addr;
    always_comb begin
        if (sel == 0) begin
            o_tvalid = axis_a.tvalid; o_tlast = axis_a.tlast; o_tdata = axis_a.tdata;
            o_tkeep = axis_a.tkeep; o_rd_en = rd_en_a; o_rd_addr = rd_addr_a;
            o_done = done_a; o_drop = drop_a;
        end else begin
            o_tvalid = axis_b.tvalid; o_tlast = axis_b.tlast; o_tdata = axis_b.tdata;
            o_tkeep = axis_b.tkeep; o_rd_en = rd_en_b; o_rd_addr = rd_addr_b;
            o_done = done_b; o_drop = drop_b;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_req(input logic wd, input logic ur, input logic [2:0] tc,
                            input logic [1:0] at, input logic [15:0] rid, input logic [7:0] tag,
                            input logic [12:0] addr, input logic [3:0] be);
        req_compl_wd = wd; req_ur = ur; req_tc = tc; req_attr = at;
        req_rid = rid; req_tag = tag; req_addr = addr; req_be = be;
        req_compl = 1'b1;
        tick();
        req_compl = 1'b0;
    endtask

    // Collects one TLP with the given stall counts; returns what was observed.
    task automatic run_tlp(input int stall0, input int stall1,
                           output logic [63:0] b0, output logic [63:0] b1,
                           output logic [7:0] k0, output logic [7:0] k1,
                           output logic l0, output logic l1,
                           output int n_rd, output logic [10:0] ra, output int n_done,
                           output logic done_next, output logic stable, output logic tmo);
        int w;
        b0 = '0; b1 = '0; k0 = '0; k1 = '0; l0 = 1'b0; l1 = 1'b0; ra = '0;
        n_rd = 0; n_done = 0; done_next = 1'b0; stable = 1'b1; tmo = 1'b0; w = 0;
        while (!o_tvalid && w < 40) begin
            if (o_rd_en) begin n_rd++; ra = o_rd_addr; end
            if (o_done) n_done++;
            tick(); w++;
        end
        if (!o_tvalid) begin tmo = 1'b1; return; end
        b0 = o_tdata; k0 = o_tkeep; l0 = o_tlast;
        for (int i = 0; i < stall0; i++) begin
            tick();
            if (o_tdata !== b0 || o_tkeep !== k0 || o_tlast !== l0 || o_tvalid !== 1'b1) stable = 1'b0;
            if (o_done) n_done++;
        end
        tready = 1'b1; tick(); tready = 1'b0;
        b1 = o_tdata; k1 = o_tkeep; l1 = o_tlast;
        if (o_tvalid !== 1'b1) stable = 1'b0;
        if (o_done) n_done++;
        for (int i = 0; i < stall1; i++) begin
            tick();
            if (o_tdata !== b1 || o_tkeep !== k1 || o_tlast !== l1 || o_tvalid !== 1'b1) stable = 1'b0;
            if (o_done) n_done++;
        end
        tready = 1'b1; tick(); tready = 1'b0;
        done_next = o_done;
        for (int i = 0; i < 6; i++) begin
            if (o_done) n_done++;
            if (o_rd_en) n_rd++;
            tick();
        end
    endtask

    logic [63:0] b0, b1;
    logic [7:0]  k0, k1;
    logic        l0, l1, dn, st, tmo;
    int          n_rd, n_done;
    logic [10:0] ra;

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            n_tests++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid[%0d]: got %b want 0", s, o_tvalid); end
            n_tests++; if ({o_tdata, o_tkeep, o_tlast} !== 73'h0) begin n_fail++; $display("FAIL reset_tdata[%0d]: got %h/%h/%b want 0", s, o_tdata, o_tkeep, o_tlast); end
            n_tests++; if ({o_rd_en, o_rd_addr, o_done, o_drop} !== 14'h0) begin n_fail++; $display("FAIL reset_misc[%0d]: got rd_en=%b rd_addr=%h done=%b drop=%b want 0", s, o_rd_en, o_rd_addr, o_done, o_drop); end
        end
        sel = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpld();
        send_req(1'b1, 1'b0, 3'd0, 2'd0, 16'h0200, 8'h05, 13'h0010, 4'hF);
        run_tlp(0, 0, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL cpld_timeout: no tvalid"); end
        n_tests++; if (n_rd != 1 || ra !== 11'h004) begin n_fail++; $display("FAIL cpld_read: got %0d reads addr %h want 1 at 004", n_rd, ra); end
        n_tests++; if (b0 !== 64'h01080004_4A000001 || k0 !== 8'hFF || l0 !== 1'b0) begin n_fail++; $display("FAIL cpld_beat0: got %h/%h/%b want 010800044a000001/ff/0", b0, k0, l0); end
        n_tests++; if (b1 !== 64'hDEADBEEF_02000510 || k1 !== 8'hFF || l1 !== 1'b1) begin n_fail++; $display("FAIL cpld_beat1: got %h/%h/%b want deadbeef02000510/ff/1", b1, k1, l1); end
        n_tests++; if (dn !== 1'b1 || n_done != 1) begin n_fail++; $display("FAIL cpld_done: got next=%b count=%0d want 1/1", dn, n_done); end
    endtask

    task automatic test_ur();
        send_req(1'b1, 1'b1, 3'd0, 2'd0, 16'hABCD, 8'h7E, 13'h0044, 4'b0001);
        run_tlp(0, 0, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
        n_tests++; if (n_rd != 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL ur_no_read: got %0d reads tmo=%b want 0/0", n_rd, tmo); end
        n_tests++; if (b0 !== 64'h01082001_0A000000) begin n_fail++; $display("FAIL ur_beat0: got %h want 010820010a000000", b0); end
        n_tests++; if (b1 !== 64'h00000000_ABCD7E44 || k1 !== 8'h0F || l1 !== 1'b1) begin n_fail++; $display("FAIL ur_beat1: got %h/%h/%b want 00000000abcd7e44/0f/1", b1, k1, l1); end
        n_tests++; if (dn !== 1'b1 || n_done != 1) begin n_fail++; $display("FAIL ur_done: got next=%b count=%0d want 1/1", dn, n_done); end
    endtask

    task automatic test_be_sweep();
        int bc_tab [16] = '{1, 1, 1, 2, 1, 3, 2, 3, 1, 4, 3, 4, 2, 4, 3, 4};
        int off_tab [16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
        logic [11:0] exp_bc;
        logic [6:0]  exp_la;
        for (int be = 0; be < 16; be++) begin
            send_req(1'b0, 1'b0, 3'd0, 2'd0, 16'h0001, 8'h00, 13'h100C, 4'(be));
            run_tlp(0, 0, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
            exp_bc = 12'(bc_tab[be]);
            exp_la = {5'd3, 2'(off_tab[be])};
            n_tests++; if (b0[43:32] !== exp_bc) begin n_fail++; $display("FAIL be_byte_count[%h]: got %0d want %0d", be, b0[43:32], exp_bc); end
            n_tests++; if (b1[6:0] !== exp_la) begin n_fail++; $display("FAIL be_lower_addr[%h]: got %h want %h", be, b1[6:0], exp_la); end
            n_tests++; if (n_done != 1 || k1 !== 8'h0F) begin n_fail++; $display("FAIL be_done[%h]: got done=%0d keep=%h want 1/0f", be, n_done, k1); end
        end
    endtask

    task automatic test_backpressure();
        send_req(1'b1, 1'b0, 3'd5, 2'b10, 16'h1234, 8'h9A, 13'h1FFC, 4'b1110);
        run_tlp(5, 3, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
        n_tests++; if (ra !== 11'h7FF || tmo !== 1'b0) begin n_fail++; $display("FAIL bp_read: got addr %h tmo=%b want 7ff/0", ra, tmo); end
        n_tests++; if (b0 !== 64'h01080003_4A502001) begin n_fail++; $display("FAIL bp_beat0: got %h want 010800034a502001", b0); end
        n_tests++; if (b1 !== 64'hAFFFC0DE_12349A7D) begin n_fail++; $display("FAIL bp_beat1: got %h want afffc0de12349a7d", b1); end
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", st); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", n_done); end
    endtask

    task automatic test_busy_drop();
        logic r1;
        logic [10:0] a1;
        n_tests++; if (o_drop !== 1'b0) begin n_fail++; $display("FAIL drop_before: got %b want 0", o_drop); end
        send_req(1'b1, 1'b0, 3'd0, 2'd0, 16'h0200, 8'h05, 13'h0010, 4'hF);
        r1 = o_rd_en; a1 = o_rd_addr;
        send_req(1'b0, 1'b0, 3'd7, 2'd3, 16'h5555, 8'hEE, 13'h0800, 4'h1);
        run_tlp(0, 0, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
        n_tests++; if (r1 !== 1'b1 || a1 !== 11'h004 || n_rd != 0) begin n_fail++; $display("FAIL drop_reads: got first=%b/%h extra=%0d want 1/004/0", r1, a1, n_rd); end
        n_tests++; if (b0 !== 64'h01080004_4A000001 || b1 !== 64'hDEADBEEF_02000510) begin n_fail++; $display("FAIL drop_tlp: got %h %h want 010800044a000001 deadbeef02000510", b0, b1); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL drop_done: got %0d want 1", n_done); end
        n_tests++; if (o_drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", o_drop); end
    endtask

    task automatic test_reset_mid(input int s);
        int w = 0;
        int nd = 0;
        logic vld_in_rst;
        sel = s;
        send_req(1'b1, 1'b0, 3'd0, 2'd0, 16'h0200, 8'h05, 13'h0010, 4'hF);
        while (!o_tvalid && w < 40) begin tick(); w++; end
        tready = 1'b1; tick(); tready = 1'b0;
        n_tests++; if (o_tvalid !== 1'b1 || o_tlast !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_beat1[%0d]: got vld=%b last=%b want 1/1", s, o_tvalid, o_tlast); end
        rst_n = 1'b0;
        #1 vld_in_rst = o_tvalid;
        n_tests++; if (vld_in_rst !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid[%0d]: got %b want 0", s, vld_in_rst); end
        for (int i = 0; i < 3; i++) begin tick(); if (o_done) nd++; end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin tick(); if (o_done) nd++; end
        n_tests++; if (nd != 0 || o_drop !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done[%0d]: got done=%0d drop=%b want 0/0", s, nd, o_drop); end
        send_req(1'b1, 1'b0, 3'd0, 2'd0, 16'h0200, 8'h05, 13'h0010, 4'hF);
        run_tlp(1, 1, b0, b1, k0, k1, l0, l1, n_rd, ra, n_done, dn, st, tmo);
        n_tests++; if (tmo !== 1'b0 || b0 !== 64'h01080004_4A000001 || b1 !== 64'hDEADBEEF_02000510) begin n_fail++; $display("FAIL rstmid_after[%0d]: got %h %h tmo=%b want 010800044a000001 deadbeef02000510", s, b0, b1, tmo); end
        n_tests++; if (n_done != 1 || n_rd != 1) begin n_fail++; $display("FAIL rstmid_after_done[%0d]: got done=%0d reads=%0d want 1/1", s, n_done, n_rd); end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_cpld();
        test_ur();
        test_be_sweep();
        test_backpressure();
        test_busy_drop();
        test_reset_mid(0);
        test_reset_mid(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
